// File: rtl/oci_monitor_pkg.sv
// Shared constants for the OCI debug-monitor memory: jdo field positions,
// register-space bit indices and the access FSM state encoding.
package oci_monitor_pkg;

    localparam int JDO_RD        = 37;
    localparam int JDO_CLR_READY = 36;
    localparam int JDO_CLR_ERROR = 35;
    localparam int JDO_DATA_MSB  = 34;
    localparam int JDO_DATA_LSB  = 3;
    localparam int JDO_ADDR_LSB  = 17;

    localparam int REG_READY_BIT = 0;
    localparam int REG_ERROR_BIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        J_RD = 2'd1,
        C_RD = 2'd2
    } mon_state_t;

endpackage

// File: rtl/oci_monitor_mem_if.sv
// CPU-side Avalon-MM slave bus of the debug monitor; address MSB selects the
// control/status register instead of RAM.
interface oci_monitor_mem_if #(
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W:0] avs_address;
    logic            avs_read;
    logic            avs_write;
    logic [31:0]     avs_writedata;
    logic [3:0]      avs_byteenable;
    logic [31:0]     avs_readdata;
    logic            avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/oci_monitor_ram.sv
// Single-port 32-bit debug RAM: byte-lane write enables, registered read data
// (read-before-write), one cycle of read latency, no reset on contents.
module oci_monitor_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    output logic [31:0]       q
);
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem [0:(2**ADDR_W)-1];
        logic [7:0] q_b;

        always_ff @(posedge clk) begin
            if (we[g]) mem[addr] <= wdata[8*g +: 8];
            q_b <= mem[addr];
        end

        assign q[8*g +: 8] = q_b;
    end
endmodule

// File: rtl/oci_monitor_mem.sv
// Debug monitor RAM + ready/error register shared by the JTAG debug slave and a
// CPU Avalon-MM slave. JTAG always wins the single RAM port. ADDR_W must be <= 17.
module oci_monitor_mem
    import oci_monitor_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter bit INIT_READY = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [37:0]      jdo,
    input  logic             take_action_ocimem_a,
    input  logic             take_no_action_ocimem_a,
    input  logic             take_action_ocimem_b,
    output logic [31:0]      MonDReg,
    output logic             monitor_ready,
    output logic             monitor_error,
    oci_monitor_mem_if.slave avs
);
    mon_state_t        state, state_nxt;
    logic [ADDR_W-1:0] mon_a_reg, mon_a_nxt, a_base, jdo_addr, ram_addr;
    logic [3:0]        ram_we;
    logic [31:0]       ram_wdata, ram_q, rdata_q, reg_val;
    logic              jtag_any, jtag_rd, cpu_free, reg_sel;
    logic              cpu_ram_rd, cpu_ram_wr, cpu_reg_wr;
    logic              unused_jdo;

    assign unused_jdo = ^jdo[JDO_DATA_LSB-1:0];

    oci_monitor_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    always_comb begin
        jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
        jtag_any   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
        jtag_rd    = (take_action_ocimem_a | take_no_action_ocimem_a) & jdo[JDO_RD];
        // The J_RD post-increment is folded in here so a strobe landing in J_RD
        // still sees the up-to-date pointer.
        a_base     = (state == J_RD) ? mon_a_reg + ADDR_W'(1) : mon_a_reg;
        cpu_free   = (state == IDLE) && !jtag_any;
        reg_sel    = avs.avs_address[ADDR_W];
        cpu_ram_rd = cpu_free && avs.avs_read && !reg_sel;
        cpu_ram_wr = cpu_free && avs.avs_write && !reg_sel;
        cpu_reg_wr = cpu_free && avs.avs_write && reg_sel && avs.avs_byteenable[0];

        mon_a_nxt = a_base;
        ram_addr  = avs.avs_address[ADDR_W-1:0];
        ram_we    = 4'h0;
        ram_wdata = avs.avs_writedata;
        if (take_action_ocimem_a) begin
            mon_a_nxt = jdo_addr;
            ram_addr  = jdo_addr;
        end else if (take_action_ocimem_b) begin
            ram_addr  = a_base;
            ram_we    = 4'hF;
            ram_wdata = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
            mon_a_nxt = a_base + ADDR_W'(1);
        end else if (take_no_action_ocimem_a) begin
            ram_addr  = a_base;
        end else if (cpu_ram_wr) begin
            ram_we    = avs.avs_byteenable;
        end

        state_nxt = IDLE;
        if (jtag_rd)         state_nxt = J_RD;
        else if (cpu_ram_rd) state_nxt = C_RD;
    end

    always_comb begin
        reg_val                = '0;
        reg_val[REG_READY_BIT] = monitor_ready;
        reg_val[REG_ERROR_BIT] = monitor_error;

        avs.avs_waitrequest = 1'b0;
        if (!reset_n) begin
            avs.avs_waitrequest = 1'b1;
        end else begin
            case (state)
                C_RD:    avs.avs_waitrequest = 1'b0;
                J_RD:    avs.avs_waitrequest = avs.avs_read | avs.avs_write;
                default: avs.avs_waitrequest = jtag_any ? (avs.avs_read | avs.avs_write) : cpu_ram_rd;
            endcase
        end

        // C_RD presents the RAM output directly; rdata_q only holds it afterwards.
        avs.avs_readdata = rdata_q;
        if (state == C_RD)
            avs.avs_readdata = ram_q;
        else if (reset_n && cpu_free && avs.avs_read && reg_sel)
            avs.avs_readdata = reg_val;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            mon_a_reg     <= '0;
            MonDReg       <= '0;
            rdata_q       <= '0;
            monitor_ready <= INIT_READY;
            monitor_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            mon_a_reg <= mon_a_nxt;
            if (state == J_RD) MonDReg <= ram_q;
            if (state == C_RD) rdata_q <= ram_q;

            if (cpu_reg_wr) begin
                if (avs.avs_writedata[REG_READY_BIT]) monitor_ready <= 1'b1;
                if (avs.avs_writedata[REG_ERROR_BIT]) monitor_error <= 1'b1;
            end
            // JTAG clears come last so they override a same-cycle CPU set.
            if (take_action_ocimem_a) begin
                if (jdo[JDO_CLR_READY]) monitor_ready <= 1'b0;
                if (jdo[JDO_CLR_ERROR]) monitor_error <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_oci_monitor_mem.sv
// Scoreboard bench for oci_monitor_mem: stimulus tasks queue expected results,
// a negedge monitor pops and compares them as the DUT presents outputs.
module tb_oci_monitor_mem;
    localparam int ADDR_W     = 8;
    localparam bit INIT_READY = 1'b0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        ta_a = 1'b0, tna_a = 1'b0, tb_s = 1'b0;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    oci_monitor_mem_if #(.ADDR_W(ADDR_W)) avs_if ();

    oci_monitor_mem #(.ADDR_W(ADDR_W), .INIT_READY(INIT_READY)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_no_action_ocimem_a (tna_a),
        .take_action_ocimem_b    (tb_s),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .avs                     (avs_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          due;
        logic [31:0] val;
        int          sel;
    } tchk_t;

    tchk_t       chk_q[$];
    logic [31:0] cpu_q[$];
    tchk_t       mc;
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] exp_mon = '0;
    logic        exp_rdy = INIT_READY, exp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_chk(input string n, input int due, input logic [31:0] v, input int sel);
        tchk_t c;
        c.name = n; c.due = due; c.val = v; c.sel = sel;
        chk_q.push_back(c);
    endfunction

    function automatic logic [37:0] jdo_a(input bit rd, input bit cr, input bit ce, input logic [7:0] addr);
        logic [37:0] j;
        j = '0; j[37] = rd; j[36] = cr; j[35] = ce; j[17 +: 8] = addr;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        logic [37:0] j;
        j = '0; j[34:3] = data;
        return j;
    endfunction

    // Monitor: timed JTAG-side checks and CPU read completions.
    always @(negedge clk) begin
        if (reset_n) begin
            while (chk_q.size() > 0 && chk_q[0].due <= cyc) begin
                mc = chk_q.pop_front();
                case (mc.sel)
                    0:       check(mc.name, MonDReg, mc.val);
                    1:       check(mc.name, {31'b0, monitor_ready}, mc.val);
                    default: check(mc.name, {31'b0, monitor_error}, mc.val);
                endcase
            end
            if (avs_if.avs_read && !avs_if.avs_waitrequest) begin
                if (cpu_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL cpu_rd_unexpected: got %h, expected no completion", avs_if.avs_readdata);
                end else begin
                    check("cpu_rd", avs_if.avs_readdata, cpu_q.pop_front());
                end
            end
            if (ta_a && tb_s) begin
                n_cmp++; n_bad++;
                $display("FAIL jtag_a_b_overlap: got both strobes, expected at most one");
            end
        end
    end

    task automatic jtag_a(input string tag, input bit rd, input bit cr, input bit ce,
                          input logic [7:0] addr, input logic [31:0] exp_rd);
        @(posedge clk); #1;
        jdo = jdo_a(rd, cr, ce, addr); ta_a = 1'b1;
        if (cr) exp_rdy = 1'b0;
        if (ce) exp_err = 1'b0;
        push_chk({tag, "_ready"}, cyc + 1, 32'(exp_rdy), 1);
        push_chk({tag, "_error"}, cyc + 1, 32'(exp_err), 2);
        if (rd) begin
            push_chk({tag, "_hold"}, cyc + 1, exp_mon, 0);
            exp_mon = exp_rd;
            push_chk({tag, "_mon"}, cyc + 2, exp_mon, 0);
        end
        @(posedge clk); #1;
        ta_a = 1'b0;
    endtask

    task automatic jtag_next(input string tag, input logic [31:0] exp_rd);
        @(posedge clk); #1;
        jdo = jdo_a(1'b1, 1'b0, 1'b0, 8'h00); tna_a = 1'b1;
        push_chk({tag, "_hold"}, cyc + 1, exp_mon, 0);
        exp_mon = exp_rd;
        push_chk({tag, "_mon"}, cyc + 2, exp_mon, 0);
        @(posedge clk); #1;
        tna_a = 1'b0;
    endtask

    task automatic jtag_b(input logic [31:0] data);
        @(posedge clk); #1;
        jdo = jdo_b(data); tb_s = 1'b1;
        @(posedge clk); #1;
        tb_s = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [8:0] addr, input logic [31:0] exp, input int exp_wait);
        int w = 0;
        bit done = 1'b0;
        @(posedge clk); #1;
        avs_if.avs_address = addr; avs_if.avs_read = 1'b1;
        cpu_q.push_back(exp);
        while (!done) begin
            @(negedge clk);
            if (!avs_if.avs_waitrequest) done = 1'b1;
            else begin
                w++;
                if (w > 50) done = 1'b1;
            end
        end
        check({tag, "_wait"}, 32'(w), 32'(exp_wait));
        @(posedge clk); #1;
        avs_if.avs_read = 1'b0;
    endtask

    task automatic cpu_write(input string tag, input logic [8:0] addr, input logic [31:0] data, input logic [3:0] be);
        int w = 0;
        bit done = 1'b0;
        @(posedge clk); #1;
        avs_if.avs_address = addr; avs_if.avs_writedata = data;
        avs_if.avs_byteenable = be; avs_if.avs_write = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (!avs_if.avs_waitrequest) done = 1'b1;
            else begin
                w++;
                if (w > 50) done = 1'b1;
            end
        end
        check({tag, "_wait"}, 32'(w), 32'd0);
        if (addr[8] && be[0]) begin
            if (data[0]) exp_rdy = 1'b1;
            if (data[1]) exp_err = 1'b1;
        end
        @(posedge clk); #1;
        avs_if.avs_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        avs_if.avs_address = '0; avs_if.avs_read = 1'b0; avs_if.avs_write = 1'b0;
        avs_if.avs_writedata = '0; avs_if.avs_byteenable = '0;

        #12;
        check("rst_mondreg", MonDReg, 32'h0);
        check("rst_ready", {31'b0, monitor_ready}, 32'(INIT_READY));
        check("rst_error", {31'b0, monitor_error}, 32'h0);
        check("rst_wait", {31'b0, avs_if.avs_waitrequest}, 32'h1);
        check("rst_rdata", avs_if.avs_readdata, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_wait", {31'b0, avs_if.avs_waitrequest}, 32'h0);

        // JTAG write then read, burst read-next, pointer continuity
        jtag_a("w_addr", 1'b0, 1'b0, 1'b0, 8'h10, 32'h0);
        jtag_b(32'hDEADBEEF);
        jtag_b(32'h12345678);
        jtag_a("rd10", 1'b1, 1'b0, 1'b0, 8'h10, 32'hDEADBEEF);
        jtag_next("rdnext11", 32'h12345678);
        jtag_b(32'hCAFEF00D);
        jtag_a("rd12", 1'b1, 1'b0, 1'b0, 8'h12, 32'hCAFEF00D);

        // Pointer wrap at 0xFF
        jtag_a("w_ff", 1'b0, 1'b0, 1'b0, 8'hFF, 32'h0);
        jtag_b(32'h0F0F0F0F);
        jtag_b(32'h55AA55AA);
        jtag_a("rd00", 1'b1, 1'b0, 1'b0, 8'h00, 32'h55AA55AA);
        jtag_a("p_ff", 1'b0, 1'b0, 1'b0, 8'hFF, 32'h0);
        jtag_next("rdnext_ff", 32'h0F0F0F0F);
        jtag_next("rdnext_wrap", 32'h55AA55AA);

        // CPU byte-enable write: lanes 0 and 2 replaced
        cpu_write("cw_full", 9'h005, 32'h11223344, 4'b1111);
        cpu_write("cw_be", 9'h005, 32'hAABBCCDD, 4'b0101);
        jtag_a("rd05", 1'b1, 1'b0, 1'b0, 8'h05, 32'h11BB33DD);
        cpu_read("cr05", 9'h005, 32'h11BB33DD, 1);
        cpu_read("cr10", 9'h010, 32'hDEADBEEF, 1);

        // Register-space handshake
        cpu_write("cw_reg3", 9'h100, 32'h3, 4'b0001);
        cpu_read("crreg3", 9'h1FF, 32'h3, 0);
        jtag_a("clr_rdy", 1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
        cpu_read("crreg2", 9'h100, 32'h2, 0);
        cpu_write("cw_nobe", 9'h100, 32'h1, 4'b1110);
        cpu_write("cw_zero", 9'h100, 32'h0, 4'b0001);
        cpu_read("crreg2b", 9'h100, 32'h2, 0);
        jtag_a("clr_err", 1'b0, 1'b0, 1'b1, 8'h00, 32'h0);
        cpu_read("crreg0", 9'h100, 32'h0, 0);

        // Collision: CPU RAM read in the same cycle as a JTAG read strobe
        fork
            cpu_read("coll_cpu", 9'h005, 32'h11BB33DD, 3);
            jtag_a("coll_j", 1'b1, 1'b0, 1'b0, 8'h10, 32'hDEADBEEF);
        join

        // Reset in the middle of J_RD
        cpu_write("cw_reg3b", 9'h100, 32'h3, 4'b0001);
        repeat (3) @(posedge clk);
        #1;
        jdo = jdo_a(1'b1, 1'b0, 1'b0, 8'h12); ta_a = 1'b1;
        @(posedge clk); #1;
        ta_a = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_mondreg", MonDReg, 32'h0);
        check("mid_rst_ready", {31'b0, monitor_ready}, 32'(INIT_READY));
        check("mid_rst_error", {31'b0, monitor_error}, 32'h0);
        check("mid_rst_wait", {31'b0, avs_if.avs_waitrequest}, 32'h1);
        check("mid_rst_rdata", avs_if.avs_readdata, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        exp_mon = '0; exp_rdy = INIT_READY; exp_err = 1'b0;
        repeat (2) @(negedge clk);
        check("after_rst_mondreg", MonDReg, 32'h0);
        check("after_rst_wait", {31'b0, avs_if.avs_waitrequest}, 32'h0);
        cpu_read("after_rst_reg", 9'h100, {30'b0, exp_err, exp_rdy}, 0);
        jtag_a("after_rst_w", 1'b0, 1'b0, 1'b0, 8'h20, 32'h0);
        jtag_b(32'h600DF00D);
        jtag_a("after_rst_rd", 1'b1, 1'b0, 1'b0, 8'h20, 32'h600DF00D);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("chk_q_left", 32'(chk_q.size()), 32'd0);
        check("cpu_q_left", 32'(cpu_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
